hbm_cmd_packer: RTL and testbench
=================================

HBM_CMD_PACKER -- requirements
Module: hbm_cmd_packer

Interface
REQ-001 SHALL provide parameter SLOTS, default 4: command slots accepted per input bundle.
REQ-002 SHALL provide parameter BEAT_SLOTS, default 2: slots per output beat; SLOTS divisible by BEAT_SLOTS.
REQ-003 SHALL provide parameter DEPTH, default 4: bundle FIFO entries, power of two, >=2.
REQ-004 SHALL provide parameter WDATA_W, default 512: write data width per bundle.
REQ-005 SHALL use reset rst (synchronous, active-high) and clock clk.
REQ-006 SHALL have: clk  in  1  clock; rst  in  1  reset.
REQ-007 SHALL have: in_valid  in  1  bundle present; in_ready  out  1  bundle accepted when both high.
REQ-008 SHALL have: wr, rd, pre, act, ref, nop, ap, pall, sel_ch, pc  in  SLOTS each  per-slot command flags.
REQ-009 SHALL have: ch  in  SLOTS*CH_W  per-slot channel for sel_ch; bg, bank, col, row  in  SLOTS*field width  per-slot address.
REQ-010 SHALL have: wdata  in  WDATA_W  bundle write data.
REQ-011 SHALL have: out_valid  out  1; out_ready  in  1; out_slots  out  BEAT_SLOTS*SLOT_W  packed slots; out_wdata  out  WDATA_W; out_last  out  1  final beat of bundle.

Function
REQ-012 Per slot, SHALL encode by priority wr>rd>pre>act>ref>nop>sel_ch>none: WRA/WR (ap), RDA/RD (ap), PREA/PREE (pall), ACT, REF, NOP, NOP, NOP.
REQ-013 Packed slot SHALL be {ch_id, pc, bg+bank, col, row, cmd_type}, slot 0 in least-significant position.
REQ-014 Channel: sel_ch on slot i SHALL apply ch[i] to slot i and all later slots of the bundle, persisting to later bundles until next sel_ch; multiple sel_ch in one bundle apply in slot order.
REQ-015 in_ready SHALL equal !full; no combinational path from out_ready to in_ready.
REQ-016 Accepted bundle SHALL be encoded and written to FIFO same edge; first beat valid next cycle at earliest.
REQ-017 Serializer SHALL emit SLOTS/BEAT_SLOTS beats per bundle in slot order, advancing only on out_valid&&out_ready; out_valid held with payload stable while out_ready low.
REQ-018 out_last SHALL be high on final beat; FIFO pop on final-beat handshake.
REQ-019 out_wdata SHALL carry the bundle's wdata on every beat of that bundle.
REQ-020 Simultaneous push and final-beat pop when full SHALL be impossible (in_ready low); when not full, both SHALL occur, count unchanged.
REQ-021 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-022 When empty, out_valid=0, out_slots cmd fields all ones (idle NOP), out_last=0.

Reset
REQ-023 rst SHALL flush FIFO, zero pointers/beat counter/channel register, drive in_ready=1, out_valid=0, out_last=0, out_wdata=0, out_slots cmd fields all ones, other fields 0.
REQ-024 rst mid-bundle SHALL discard partial beats; next beat after reset starts a new bundle at slot 0.

Configuration
REQ-025 Macro HBM_CMD_PACKER_PARITY_EN defined: each packed slot SHALL gain one MSB even-parity bit over its other bits (SLOT_W+1); undefined: no parity bit, SLOT_W unchanged.

Structure
REQ-026 Command codes (WR, WRA, RD, RDA, PREE, PREA, ACT, REF, NOP), CMD_TYPE_W, CH_W, ROW/COL/BA/PC widths and SLOT_W SHALL live in shared package hbm_cmd_pkg.
REQ-027 Bundle storage SHALL be sub-module hbm_cmd_fifo (sync FIFO, DEPTH, width SLOTS*SLOT_W+WDATA_W).

Verification
REQ-028 Bundle {ACT,NOP,WR+ap,RD}, out_ready=1 -> beats {ACT,NOP},{WRA,RD}, out_last on beat 2, first beat cycle after accept.
REQ-029 sel_ch slot1 ch=5 then slot2 RD -> slots 0 ch=0, slots1-3 ch=5; next bundle all ch=5.
REQ-030 out_ready=0, push 4 bundles -> in_ready low after 4th; fifth held; release -> 8 beats in order, no loss.
REQ-031 out_ready toggling 1/0 each cycle -> payload stable while stalled, beats never skipped or duplicated.
REQ-032 rst asserted after first beat of bundle -> out_valid=0 next cycle, FIFO empty, channel 0.
REQ-033 PARITY_EN build, slot with odd popcount -> parity bit 1; without macro, out_slots width BEAT_SLOTS*SLOT_W.

Source files
------------

// File: rtl/hbm_cmd_pkg.sv
// Shared command codes, field widths and slot packing helpers for the HBM
// command packer. Optional feature macro: HBM_CMD_PACKER_PARITY_EN adds an
// even-parity MSB to every packed slot.
package hbm_cmd_pkg;

  localparam int CMD_TYPE_W = 4;
  localparam int CH_W       = 3;
  localparam int PC_W       = 1;
  localparam int BG_W       = 2;
  localparam int BA_W       = 2;
  localparam int COL_W      = 6;
  localparam int ROW_W      = 14;
  localparam int SLOT_W     = CH_W + PC_W + BG_W + BA_W + COL_W + ROW_W + CMD_TYPE_W;

`ifdef HBM_CMD_PACKER_PARITY_EN
  localparam int PKT_W = SLOT_W + 1;
`else
  localparam int PKT_W = SLOT_W;
`endif

  // NOP is all ones so an idle slot reads as a NOP on the bus.
  typedef enum logic [CMD_TYPE_W-1:0] {
    CMD_WR   = 4'h0,
    CMD_WRA  = 4'h1,
    CMD_RD   = 4'h2,
    CMD_RDA  = 4'h3,
    CMD_PREE = 4'h4,
    CMD_PREA = 4'h5,
    CMD_ACT  = 4'h6,
    CMD_REF  = 4'h7,
    CMD_NOP  = 4'hF
  } cmd_t;

  // Priority encode one slot's flags: wr > rd > pre > act > ref > nop;
  // sel_ch-only and empty slots fall through to NOP.
  function automatic cmd_t encode_cmd(input logic wr, input logic rd, input logic pre,
                                      input logic act, input logic refresh, input logic nop,
                                      input logic ap, input logic pall);
    cmd_t c;
    c = CMD_NOP;
    if (wr)           c = ap ? CMD_WRA : CMD_WR;
    else if (rd)      c = ap ? CMD_RDA : CMD_RD;
    else if (pre)     c = pall ? CMD_PREA : CMD_PREE;
    else if (act)     c = CMD_ACT;
    else if (refresh) c = CMD_REF;
    else if (nop)     c = CMD_NOP;
    return c;
  endfunction

  // Slot layout, cmd_type in the LSBs: {ch_id, pc, bg, bank, col, row, cmd_type}.
  function automatic logic [PKT_W-1:0] pack_slot(input logic [CH_W-1:0] ch_id,
                                                 input logic [PC_W-1:0] pc,
                                                 input logic [BG_W-1:0] bg,
                                                 input logic [BA_W-1:0] ba,
                                                 input logic [COL_W-1:0] col,
                                                 input logic [ROW_W-1:0] row,
                                                 input logic [CMD_TYPE_W-1:0] cmd);
    logic [SLOT_W-1:0] s;
    s = {ch_id, pc, bg, ba, col, row, cmd};
`ifdef HBM_CMD_PACKER_PARITY_EN
    return {^s, s};
`else
    return s;
`endif
  endfunction

  function automatic logic [PKT_W-1:0] idle_slot();
    return pack_slot('0, '0, '0, '0, '0, '0, CMD_NOP);
  endfunction

endpackage

// File: rtl/hbm_cmd_fifo.sv
// Synchronous bundle FIFO with first-word-fall-through read data.
module hbm_cmd_fifo
  #(parameter int DEPTH = 4,
    parameter int WIDTH = 32)
  (input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hbm_cmd_packer.sv
// Packs bundles of per-slot HBM command flags into encoded slots, queues them
// with their write data, and serialises each bundle into BEAT_SLOTS-wide beats.
// Optional feature macro: HBM_CMD_PACKER_PARITY_EN (per-slot even parity MSB).
module hbm_cmd_packer
  import hbm_cmd_pkg::*;
  #(parameter int SLOTS      = 4,
    parameter int BEAT_SLOTS = 2,
    parameter int DEPTH      = 4,
    parameter int WDATA_W    = 512)
  (input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SLOTS-1:0]              wr,
   input  logic [SLOTS-1:0]              rd,
   input  logic [SLOTS-1:0]              pre,
   input  logic [SLOTS-1:0]              act,
   input  logic [SLOTS-1:0]              refresh,
   input  logic [SLOTS-1:0]              nop,
   input  logic [SLOTS-1:0]              ap,
   input  logic [SLOTS-1:0]              pall,
   input  logic [SLOTS-1:0]              sel_ch,
   input  logic [SLOTS*PC_W-1:0]         pc,
   input  logic [SLOTS*CH_W-1:0]         ch,
   input  logic [SLOTS*BG_W-1:0]         bg,
   input  logic [SLOTS*BA_W-1:0]         bank,
   input  logic [SLOTS*COL_W-1:0]        col,
   input  logic [SLOTS*ROW_W-1:0]        row,
   input  logic [WDATA_W-1:0]            wdata,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BEAT_SLOTS*PKT_W-1:0]   out_slots,
   output logic [WDATA_W-1:0]            out_wdata,
   output logic                          out_last);

  localparam int NBEATS  = SLOTS / BEAT_SLOTS;
  localparam int BEAT_CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BEAT_W  = BEAT_SLOTS * PKT_W;
  localparam int FIFO_W  = SLOTS * PKT_W + WDATA_W;

  logic [CH_W-1:0]        chan_q;
  logic [CH_W-1:0]        chan_next;
  logic [SLOTS*PKT_W-1:0] enc_slots;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [FIFO_W-1:0]      fifo_dout;
  logic [BEAT_CW-1:0]     beat_q;
  logic                   last_beat;

  // Encode every slot; a sel_ch on slot i retargets slot i and all later slots.
  always_comb begin
    chan_next = chan_q;
    enc_slots = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (sel_ch[i]) chan_next = ch[i*CH_W +: CH_W];
      enc_slots[i*PKT_W +: PKT_W] = pack_slot(chan_next,
                                              pc[i*PC_W +: PC_W],
                                              bg[i*BG_W +: BG_W],
                                              bank[i*BA_W +: BA_W],
                                              col[i*COL_W +: COL_W],
                                              row[i*ROW_W +: ROW_W],
                                              encode_cmd(wr[i], rd[i], pre[i], act[i],
                                                         refresh[i], nop[i], ap[i], pall[i]));
    end
  end

  assign in_ready = !full;
  assign push     = in_valid && !full;

  // Channel selection persists across bundles until the next sel_ch.
  always_ff @(posedge clk) begin
    if (rst)       chan_q <= '0;
    else if (push) chan_q <= chan_next;
  end

  hbm_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(FIFO_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({wdata, enc_slots}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign last_beat = (beat_q == BEAT_CW'(NBEATS - 1));
  assign out_valid = !empty;
  assign out_last  = out_valid && last_beat;
  assign pop       = out_valid && out_ready && last_beat;

  // Beat index within the head bundle; returns to slot 0 after the final beat.
  always_ff @(posedge clk) begin
    if (rst)                         beat_q <= '0;
    else if (out_valid && out_ready) beat_q <= last_beat ? '0 : beat_q + 1'b1;
  end

  // Select the current beat of the head bundle, or idle NOPs when empty.
  always_comb begin
    out_slots = {BEAT_SLOTS{idle_slot()}};
    out_wdata = '0;
    if (!empty) begin
      out_wdata = fifo_dout[SLOTS*PKT_W +: WDATA_W];
      for (int b = 0; b < NBEATS; b++) begin
        if (beat_q == BEAT_CW'(b)) out_slots = fifo_dout[b*BEAT_W +: BEAT_W];
      end
    end
  end

endmodule

// File: tb/tb_hbm_cmd_packer.sv
// Scoreboard bench for hbm_cmd_packer: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares on every output handshake.
module tb_hbm_cmd_packer;
  import hbm_cmd_pkg::*;

  localparam int SLOTS      = 4;
  localparam int BEAT_SLOTS = 2;
  localparam int DEPTH      = 4;
  localparam int WDATA_W    = 512;
  localparam int BEAT_W     = BEAT_SLOTS * PKT_W;

  localparam logic [9:0] F_WR   = 10'h200;
  localparam logic [9:0] F_RD   = 10'h100;
  localparam logic [9:0] F_PRE  = 10'h080;
  localparam logic [9:0] F_ACT  = 10'h040;
  localparam logic [9:0] F_REF  = 10'h020;
  localparam logic [9:0] F_NOP  = 10'h010;
  localparam logic [9:0] F_AP   = 10'h008;
  localparam logic [9:0] F_PALL = 10'h004;
  localparam logic [9:0] F_SEL  = 10'h002;
  localparam logic [9:0] F_PC   = 10'h001;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [SLOTS-1:0] wr, rd, pre, act, refresh, nop, ap, pall, sel_ch;
  logic [SLOTS*PC_W-1:0]  pc;
  logic [SLOTS*CH_W-1:0]  ch;
  logic [SLOTS*BG_W-1:0]  bg;
  logic [SLOTS*BA_W-1:0]  bank;
  logic [SLOTS*COL_W-1:0] col;
  logic [SLOTS*ROW_W-1:0] row;
  logic [WDATA_W-1:0]     wdata, out_wdata;
  logic [BEAT_W-1:0]      out_slots;

  typedef struct packed {
    logic [BEAT_W-1:0]  slots;
    logic [WDATA_W-1:0] wd;
    logic               last;
  } beat_t;

  beat_t sb[$];
  beat_t cur_b, prev_b;
  logic  stall_prev;
  int    checks = 0;
  int    errors = 0;
  int    bundle_n = 0;

  logic [9:0]            f   [SLOTS];
  logic [CH_W-1:0]       sc  [SLOTS];
  logic [CMD_TYPE_W-1:0] xc  [SLOTS];
  logic [CH_W-1:0]       xch [SLOTS];

  hbm_cmd_packer #(.SLOTS(SLOTS), .BEAT_SLOTS(BEAT_SLOTS), .DEPTH(DEPTH), .WDATA_W(WDATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wr(wr), .rd(rd), .pre(pre), .act(act), .refresh(refresh), .nop(nop),
    .ap(ap), .pall(pall), .sel_ch(sel_ch), .pc(pc), .ch(ch), .bg(bg),
    .bank(bank), .col(col), .row(row), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_slots(out_slots),
    .out_wdata(out_wdata), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur_b = {out_slots, out_wdata, out_last};

  // Bench-side slot layout: {ch, pc, bg, bank, col, row, cmd}, optional parity MSB.
  function automatic logic [PKT_W-1:0] exp_slot(input logic [CH_W-1:0] c, input logic [PC_W-1:0] p,
                                                input logic [BG_W-1:0] g, input logic [BA_W-1:0] b,
                                                input logic [COL_W-1:0] cl, input logic [ROW_W-1:0] r,
                                                input logic [CMD_TYPE_W-1:0] cmd);
    logic [SLOT_W-1:0] s;
    s = {c, p, g, b, cl, r, cmd};
`ifdef HBM_CMD_PACKER_PARITY_EN
    return {^s, s};
`else
    return s;
`endif
  endfunction

  task automatic check_output(input string name, input logic [1023:0] actual, input logic [1023:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one bundle from f/sc, wait (bounded) for acceptance, queue its beats.
  task automatic apply_stimulus(input logic [WDATA_W-1:0] wd);
    logic [SLOTS*PKT_W-1:0] exp_all;
    beat_t b;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < SLOTS; i++) begin
      {wr[i], rd[i], pre[i], act[i], refresh[i], nop[i], ap[i], pall[i], sel_ch[i], pc[i]} = f[i];
      ch[i*CH_W +: CH_W]     = sc[i];
      bg[i*BG_W +: BG_W]     = BG_W'(i);
      bank[i*BA_W +: BA_W]   = BA_W'(3 - i);
      col[i*COL_W +: COL_W]  = COL_W'(bundle_n * 4 + i);
      row[i*ROW_W +: ROW_W]  = ROW_W'(bundle_n * 256 + i);
      exp_all[i*PKT_W +: PKT_W] = exp_slot(xch[i], f[i][0], BG_W'(i), BA_W'(3 - i),
                                           COL_W'(bundle_n * 4 + i), ROW_W'(bundle_n * 256 + i), xc[i]);
    end
    wdata = wd;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: bundle %0d got in_ready=0 expected 1", bundle_n);
    end else begin
      for (int k = 0; k < SLOTS / BEAT_SLOTS; k++) begin
        b.slots = exp_all[k*BEAT_W +: BEAT_W];
        b.wd    = wd;
        b.last  = (k == SLOTS / BEAT_SLOTS - 1);
        sb.push_back(b);
      end
    end
    bundle_n++;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    check_output("drain", 1024'(sb.size()), 1024'(0));
  endtask

  task automatic set_slot(input int i, input logic [9:0] fl, input logic [CH_W-1:0] s,
                          input logic [CMD_TYPE_W-1:0] c, input logic [CH_W-1:0] xc_ch);
    f[i] = fl; sc[i] = s; xc[i] = c; xch[i] = xc_ch;
  endtask

  task automatic check_idle(input string tag);
    logic [BEAT_W-1:0] idle;
    idle = {2{exp_slot('0, '0, '0, '0, '0, '0, CMD_NOP)}};
    check_output({tag, "_in_ready"},  1024'(in_ready),  1024'(1'b1));
    check_output({tag, "_out_valid"}, 1024'(out_valid), 1024'(1'b0));
    check_output({tag, "_out_last"},  1024'(out_last),  1024'(1'b0));
    check_output({tag, "_out_wdata"}, 1024'(out_wdata), 1024'(0));
    check_output({tag, "_out_slots"}, 1024'(out_slots), 1024'(idle));
  endtask

  // Monitor: compare each handshaken beat and hold stability across stalls.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) check_output("stall_hold", 1024'({out_valid, cur_b}), 1024'({1'b1, prev_b}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %0h expected none", cur_b);
        end else begin
          e = sb.pop_front();
          check_output("beat", 1024'(cur_b), 1024'(e));
        end
      end
      stall_prev <= out_valid && !out_ready;
      prev_b     <= cur_b;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wdata = '0;
    wr = '0; rd = '0; pre = '0; act = '0; refresh = '0; nop = '0; ap = '0; pall = '0;
    sel_ch = '0; pc = '0; ch = '0; bg = '0; bank = '0; col = '0; row = '0;
    stall_prev = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Basic bundle: ACT, NOP, WR+ap, RD with first beat one cycle after accept.
    set_slot(0, F_ACT, 0, CMD_ACT, 0);
    set_slot(1, F_NOP, 0, CMD_NOP, 0);
    set_slot(2, F_WR | F_AP, 0, CMD_WRA, 0);
    set_slot(3, F_RD, 0, CMD_RD, 0);
    apply_stimulus(512'hA1);
    @(negedge clk);
    check_output("first_beat_valid", 1024'({out_valid, out_last}), 1024'(2'b10));
    wait_drain();

    // Remaining command codes and pc bit.
    set_slot(0, F_PRE, 0, CMD_PREE, 0);
    set_slot(1, F_PRE | F_PALL, 0, CMD_PREA, 0);
    set_slot(2, F_REF | F_PC, 0, CMD_REF, 0);
    set_slot(3, F_RD | F_AP, 0, CMD_RDA, 0);
    apply_stimulus(512'hB2);

    // Priority between simultaneous flags.
    set_slot(0, F_WR | F_RD, 0, CMD_WR, 0);
    set_slot(1, F_RD | F_PRE | F_AP, 0, CMD_RDA, 0);
    set_slot(2, F_PRE | F_ACT | F_PALL, 0, CMD_PREA, 0);
    set_slot(3, F_ACT | F_REF | F_NOP, 0, CMD_ACT, 0);
    apply_stimulus(512'hB3);
    wait_drain();

    // Channel select on slot 1, then persistence into the next bundle.
    set_slot(0, F_NOP, 3, CMD_NOP, 0);
    set_slot(1, F_SEL, 5, CMD_NOP, 5);
    set_slot(2, F_RD, 6, CMD_RD, 5);
    set_slot(3, 10'h0, 7, CMD_NOP, 5);
    apply_stimulus(512'hC5);
    for (int i = 0; i < SLOTS; i++) set_slot(i, F_NOP, CH_W'(i + 1), CMD_NOP, 5);
    apply_stimulus(512'hC6);
    // Two selects in one bundle apply in slot order.
    set_slot(0, F_SEL, 2, CMD_NOP, 2);
    set_slot(1, F_WR, 0, CMD_WR, 2);
    set_slot(2, F_SEL | F_ACT, 7, CMD_ACT, 7);
    set_slot(3, 10'h0, 1, CMD_NOP, 7);
    apply_stimulus(512'hC7);
    wait_drain();

    // Fill the FIFO with out_ready low, hold a fifth bundle, then release.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_slot(0, F_ACT, 0, CMD_ACT, 7);
      set_slot(1, F_WR, 0, CMD_WR, 7);
      set_slot(2, F_RD, 0, CMD_RD, 7);
      set_slot(3, F_PRE, 0, CMD_PREE, 7);
      apply_stimulus(WDATA_W'(32'hD00 + k));
    end
    @(negedge clk);
    check_output("full_in_ready", 1024'(in_ready), 1024'(1'b0));
    for (int i = 0; i < SLOTS; i++) set_slot(i, F_REF, 0, CMD_REF, 7);
    fork
      apply_stimulus(512'hD04);
      begin
        repeat (3) @(negedge clk);
        check_output("fifth_held", 1024'(in_ready), 1024'(1'b0));
        check_output("queued_beats", 1024'(sb.size()), 1024'(8));
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Toggling out_ready while bundles stream in back to back.
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          set_slot(0, F_WR | F_AP, 0, CMD_WRA, 7);
          set_slot(1, F_NOP, 0, CMD_NOP, 7);
          set_slot(2, F_ACT, 0, CMD_ACT, 7);
          set_slot(3, F_RD, 0, CMD_RD, 7);
          apply_stimulus(WDATA_W'(32'hE00 + k));
        end
      end
      begin
        repeat (24) begin
          @(posedge clk); #1 out_ready = ~out_ready;
        end
      end
    join
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Reset after the first beat of a bundle discards the rest.
    @(posedge clk); #1 out_ready = 1'b0;
    set_slot(0, F_ACT, 0, CMD_ACT, 7);
    set_slot(1, F_WR, 0, CMD_WR, 7);
    set_slot(2, F_NOP, 0, CMD_NOP, 7);
    set_slot(3, F_RD, 0, CMD_RD, 7);
    apply_stimulus(512'hF0);
    @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("pre_reset_left", 1024'(sb.size()), 1024'(1));
    rst = 1'b1; out_ready = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle("midreset");
    rst = 1'b0; out_ready = 1'b1;

    // After reset: channel back to 0 and serialisation restarts at slot 0.
    set_slot(0, F_NOP, 0, CMD_NOP, 0);
    set_slot(1, F_ACT, 0, CMD_ACT, 0);
    set_slot(2, F_RD | F_AP, 0, CMD_RDA, 0);
    set_slot(3, F_WR, 0, CMD_WR, 0);
    apply_stimulus(512'hF1);
    wait_drain();
    @(negedge clk);
    check_output("end_idle", 1024'({out_valid, in_ready}), 1024'(2'b01));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
